// File: rtl/wbs_row_assembler.sv
// wbs_row_assembler: Wishbone slave packing write beats into data rows or instruction words,
// issuing one write strobe per completed row with row-address auto-increment.
module wbs_row_assembler #(
   parameter int WB_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_LANES = 3,
   parameter int INSTR_LANES = 2,
   parameter int TAG_WIDTH = 2,
   parameter logic [TAG_WIDTH-1:0] TAG_DATA = 2'b01,
   parameter logic [TAG_WIDTH-1:0] TAG_INSTR = 2'b10
) (
   input  logic                             CLK_I,
   input  logic                             RST_I,
   input  logic                             CYC_I,
   input  logic                             STB_I,
   input  logic                             WE_I,
   input  logic [WB_WIDTH-1:0]              DAT_I,
   input  logic [WB_WIDTH-1:0]              ADR_I,
   input  logic [TAG_WIDTH-1:0]             TGA_I,
   output logic                             ACK_O,
   output logic                             ERR_O,
   output logic [ADDR_WIDTH-1:0]            oRowAddress,
   output logic [DATA_LANES*WB_WIDTH-1:0]   oDataBus,
   output logic [INSTR_LANES*WB_WIDTH-1:0]  oInstructionBus,
   output logic                             oDataWriteEnable,
   output logic                             oInstructionWriteEnable,
   output logic                             oBusy
);
   localparam int CW = DATA_LANES > 1 ? $clog2(DATA_LANES) : 1;
   localparam logic [CW-1:0] D_LAST = CW'(DATA_LANES - 1);
   localparam logic [CW-1:0] I_LAST = CW'(INSTR_LANES - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                state_q, state_d;
   logic                  ack_q, err_q, dwe_q, iwe_q;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [TAG_WIDTH-1:0]  tag_q, tag;
   logic [WB_WIDTH-1:0]   lanes_q [DATA_LANES];
   logic                  req, is_data, is_instr, good, last;
   logic                  unused_adr;

   // The first beat of a cycle is decoded with the incoming tag, later beats with the latched one.
   always_comb begin
      tag = state_q == IDLE ? TGA_I : tag_q;
      is_data = tag == TAG_DATA;
      is_instr = tag == TAG_INSTR;
      req = CYC_I & STB_I & ~ack_q & ~err_q;
      good = req & WE_I & (is_data | is_instr);
      last = cnt_q == (is_data ? D_LAST : I_LAST);
      state_d = !CYC_I ? IDLE : req ? ACTIVE : state_q;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dwe_q <= 1'b0;
         iwe_q <= 1'b0;
         cnt_q <= '0;
         addr_q <= '0;
         tag_q <= '0;
         for (int k = 0; k < DATA_LANES; k++) lanes_q[k] <= '0;
      end else begin
         ack_q <= good;
         err_q <= req & ~good;
         dwe_q <= good & last & is_data;
         iwe_q <= good & last & is_instr;
         if (!CYC_I) cnt_q <= '0;
         else if (good) cnt_q <= last ? '0 : cnt_q + 1'b1;
         if (good) lanes_q[cnt_q] <= DAT_I;
         // Address advances on the edge that ends the strobe, so it is stable during the strobe.
         if (state_q == IDLE && req) begin
            tag_q <= TGA_I;
            addr_q <= ADR_I[ADDR_WIDTH-1:0];
         end else if (dwe_q | iwe_q) addr_q <= addr_q + 1'b1;
      end
   end

   for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
      assign oDataBus[(DATA_LANES-i)*WB_WIDTH-1 -: WB_WIDTH] = lanes_q[i];
   end

   assign oInstructionBus = oDataBus[DATA_LANES*WB_WIDTH-1 -: INSTR_LANES*WB_WIDTH];
   assign ACK_O = ack_q & STB_I;
   assign ERR_O = err_q;
   assign oRowAddress = addr_q;
   assign oDataWriteEnable = dwe_q;
   assign oInstructionWriteEnable = iwe_q;
   assign oBusy = state_q == ACTIVE;
   assign unused_adr = ^ADR_I;
endmodule
